// File: rtl/arb_pkg.sv
// Shared types and defaults for the arbiter requester.
// ARB_REQ_GRANT_TMO_EN enables the grant-wait watchdog default.
package arb_pkg;

  localparam int unsigned N_DEF         = 4;
  localparam int unsigned BURST_LEN_DEF = 3;
  localparam int unsigned PEND_MAX_DEF  = 7;
`ifdef ARB_REQ_GRANT_TMO_EN
  localparam int unsigned TMO_CYC_DEF   = 31;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    OWN     = 2'd2,
    RELEASE = 2'd3
  } req_state_t;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_req_channel.sv
// One requester channel: request FSM, pending-transaction counter and burst counter.
// ARB_REQ_GRANT_TMO_EN adds a grant-wait watchdog with a tmo_o pulse.
module arb_req_channel
  import arb_pkg::*;
#(
  parameter int unsigned BURST_LEN = BURST_LEN_DEF,
  parameter int unsigned PEND_MAX  = PEND_MAX_DEF,
`ifdef ARB_REQ_GRANT_TMO_EN
  parameter int unsigned TMO_CYC   = TMO_CYC_DEF,
`endif
  localparam int unsigned CNT_W    = cnt_width(PEND_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             gnt_i,
  output logic             req_o,
  output logic             done_o,
  output logic             ovf_o,
`ifdef ARB_REQ_GRANT_TMO_EN
  output logic             tmo_o,
`endif
  output logic [CNT_W-1:0] pend_cnt_o
);

  localparam int unsigned BW = cnt_width(BURST_LEN);
`ifdef ARB_REQ_GRANT_TMO_EN
  localparam int unsigned TW = cnt_width(TMO_CYC);
`endif

  req_state_t       state_q, state_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             req_q, req_d;
  logic             ovf_q, ovf_d;
  logic             done_c;
  logic             last_beat_c;
`ifdef ARB_REQ_GRANT_TMO_EN
  logic [TW-1:0]    wait_q, wait_d;
  logic             tmo_q, tmo_d;
  logic             tmo_hit_c;
`endif

  // Final granted cycle of the burst (REQ covers the single-beat case).
  assign last_beat_c = gnt_i &&
                       (((state_q == REQ) && (BURST_LEN == 1)) ||
                        ((state_q == OWN) && (burst_q == BW'(BURST_LEN - 1))));
`ifdef ARB_REQ_GRANT_TMO_EN
  assign tmo_hit_c = (state_q == REQ) && !gnt_i && (wait_q == TW'(TMO_CYC - 1));
`endif

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      burst_q <= '0;
      pend_q  <= '0;
      req_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ARB_REQ_GRANT_TMO_EN
      wait_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      ovf_q   <= ovf_d;
`ifdef ARB_REQ_GRANT_TMO_EN
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Next-state logic; a dropped grant in OWN simply pauses the burst.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
`ifdef ARB_REQ_GRANT_TMO_EN
    wait_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (pend_q != '0) state_d = REQ;
      end
      REQ: begin
        if (last_beat_c) begin
          state_d = RELEASE;
          burst_d = '0;
        end else if (gnt_i) begin
          state_d = OWN;
          burst_d = BW'(1);
`ifdef ARB_REQ_GRANT_TMO_EN
        end else if (tmo_hit_c) begin
          state_d = RELEASE;
        end else begin
          wait_d  = wait_q + TW'(1);
`endif
        end
      end
      OWN: begin
        if (last_beat_c) begin
          state_d = RELEASE;
          burst_d = '0;
        end else if (gnt_i) begin
          burst_d = burst_q + BW'(1);
        end
      end
      RELEASE: begin
        state_d = (pend_q != '0) ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and pending-count logic; push and done together cancel out.
  always_comb begin
    req_d  = (state_d == REQ) || (state_d == OWN);
    done_c = last_beat_c;
    ovf_d  = 1'b0;
    pend_d = pend_q;
`ifdef ARB_REQ_GRANT_TMO_EN
    tmo_d  = tmo_hit_c;
`endif
    case ({push_i, done_c})
      2'b10: begin
        if (pend_q == CNT_W'(PEND_MAX)) ovf_d = 1'b1;
        else                            pend_d = pend_q + CNT_W'(1);
      end
      2'b01:   pend_d = pend_q - CNT_W'(1);
      default: pend_d = pend_q;
    endcase
  end

  assign req_o      = req_q;
  assign done_o     = done_c;
  assign ovf_o      = ovf_q;
  assign pend_cnt_o = pend_q;
`ifdef ARB_REQ_GRANT_TMO_EN
  assign tmo_o      = tmo_q;
`endif

endmodule

// File: rtl/arbiter_requester.sv
// N-channel requester for a round-robin arbiter, with a grant-protocol checker.
// ARB_REQ_GRANT_TMO_EN adds the tmo_o port and per-channel grant-wait watchdogs.
module arbiter_requester
  import arb_pkg::*;
#(
  parameter int unsigned N         = N_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF,
  parameter int unsigned PEND_MAX  = PEND_MAX_DEF,
`ifdef ARB_REQ_GRANT_TMO_EN
  parameter int unsigned TMO_CYC   = TMO_CYC_DEF,
`endif
  localparam int unsigned CNT_W    = cnt_width(PEND_MAX)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       push_i,
  input  logic [N-1:0]       gnt_i,
  output logic [N-1:0]       req_o,
  output logic [N*CNT_W-1:0] pend_cnt_o,
  output logic [N-1:0]       done_o,
  output logic [N-1:0]       ovf_o,
`ifdef ARB_REQ_GRANT_TMO_EN
  output logic [N-1:0]       tmo_o,
`endif
  output logic               err_multi_o,
  output logic               err_unreq_o
);

  logic err_multi_q;
  logic err_unreq_q;

  // Independent channel instances.
  for (genvar i = 0; i < N; i++) begin : g_ch
    arb_req_channel #(
      .BURST_LEN (BURST_LEN),
`ifdef ARB_REQ_GRANT_TMO_EN
      .TMO_CYC   (TMO_CYC),
`endif
      .PEND_MAX  (PEND_MAX)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push_i[i]),
      .gnt_i      (gnt_i[i]),
      .req_o      (req_o[i]),
      .done_o     (done_o[i]),
      .ovf_o      (ovf_o[i]),
`ifdef ARB_REQ_GRANT_TMO_EN
      .tmo_o      (tmo_o[i]),
`endif
      .pend_cnt_o (pend_cnt_o[i*CNT_W +: CNT_W])
    );
  end

  // Grant protocol checker; reporting only, one cycle behind the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_multi_q <= 1'b0;
      err_unreq_q <= 1'b0;
    end else begin
      err_multi_q <= ($countones(gnt_i) > 1);
      err_unreq_q <= |(gnt_i & ~req_o);
    end
  end

  assign err_multi_o = err_multi_q;
  assign err_unreq_o = err_unreq_q;

endmodule

// File: tb/tb_arbiter_requester.sv
// Directed self-checking bench for arbiter_requester (defaults N=4, BURST_LEN=3, PEND_MAX=7).
module tb_arbiter_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  push;
  logic [3:0]  gnt;
  logic [3:0]  req;
  logic [11:0] pend;
  logic [3:0]  done;
  logic [3:0]  ovf;
  logic        err_multi;
  logic        err_unreq;
`ifdef ARB_REQ_GRANT_TMO_EN
  logic [3:0]  tmo;
`endif

  int tests = 0;
  int fails = 0;

  int owner = -1;
  int last  = 3;
  int n_done = 0;
  int order[$];
  logic [3:0] prev_done;
  logic       saw_err;

  always #5 clk = ~clk;

  arbiter_requester dut (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .gnt_i       (gnt),
    .req_o       (req),
    .pend_cnt_o  (pend),
    .done_o      (done),
    .ovf_o       (ovf),
`ifdef ARB_REQ_GRANT_TMO_EN
    .tmo_o       (tmo),
`endif
    .err_multi_o (err_multi),
    .err_unreq_o (err_unreq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] pend_of(input int ch);
    return pend[ch*3 +: 3];
  endfunction

  // Round-robin arbiter model: hold the owner while it requests, else rotate.
  task automatic arb_update();
    if (owner >= 0 && !req[owner]) owner = -1;
    if (owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (last + k) % 4;
        if (owner < 0 && req[c]) begin
          owner = c;
          last  = c;
        end
      end
    end
    gnt = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
  endtask

  initial begin
    rst  = 1'b1;
    push = 4'b1111;
    gnt  = 4'b0000;

    // Reset with pushes asserted: nothing may be queued
    edge_();
    #1;
    chk("rst_req", 32'(req), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'({err_multi, err_unreq, ovf}), 0);
    edge_();
    chk("rst_pend2", 32'(pend), 0);
    rst  = 1'b0;
    push = 4'b0000;
    edge_();
    chk("post_rst_pend", 32'(pend), 0);
    chk("post_rst_req", 32'(req), 0);
    edge_();
    chk("post_rst_req2", 32'(req), 0);

    // Single channel, grant one cycle after req, held for the burst
    push = 4'b0001;
    edge_();
    push = 4'b0000;
    chk("sc_pend1", 32'(pend_of(0)), 1);
    chk("sc_req_idle", 32'(req), 0);
    edge_();
    #1;
    chk("sc_req_up", 32'(req), 32'h1);
    chk("sc_done_a", 32'(done), 0);
    edge_();
    gnt = 4'b0001;
    #1;
    chk("sc_req_wait", 32'(req), 32'h1);
    chk("sc_done_g1", 32'(done), 0);
    edge_();
    #1;
    chk("sc_req_g2", 32'(req), 32'h1);
    chk("sc_done_g2", 32'(done), 0);
    edge_();
    #1;
    chk("sc_done_g3", 32'(done), 32'h1);
    chk("sc_pend_g3", 32'(pend_of(0)), 1);
    edge_();
    gnt = 4'b0000;
    #1;
    chk("sc_rel_req", 32'(req), 0);
    chk("sc_rel_done", 32'(done), 0);
    chk("sc_rel_pend", 32'(pend_of(0)), 0);
    edge_();
    chk("sc_idle_req", 32'(req), 0);
    edge_();
    chk("sc_idle_req2", 32'(req), 0);
    chk("sc_idle_pend", 32'(pend), 0);
    chk("sc_no_err", 32'({err_multi, err_unreq}), 0);

    // All channels, two transactions each, round-robin arbiter
    push = 4'b1111;
    edge_();
    edge_();
    prev_done = 4'b0000;
    saw_err   = 1'b0;
    for (int it = 0; it < 200 && n_done < 8; it++) begin
      if (it > 0) edge_();
      push = 4'b0000;
      if (prev_done != 4'b0000) chk("rr_release_gap", 32'(req & prev_done), 0);
      arb_update();
      #1;
      if (err_multi || err_unreq) saw_err = 1'b1;
      prev_done = done;
      for (int c = 0; c < 4; c++) begin
        if (done[c]) begin
          order.push_back(c);
          n_done++;
        end
      end
    end
    edge_();
    gnt = 4'b0000;
    chk("rr_release_last", 32'(req & prev_done), 0);
    if (err_multi || err_unreq) saw_err = 1'b1;
    edge_();
    edge_();
    chk("rr_count", 32'(n_done), 8);
    for (int k = 0; k < 8; k++) begin
      chk("rr_order", (k < order.size()) ? 32'(order[k]) : 32'hFF, 32'(k % 4));
    end
    chk("rr_no_err", 32'(saw_err), 0);
    chk("rr_pend_empty", 32'(pend), 0);
    chk("rr_req_idle", 32'(req), 0);

    // Overflow on channel 2, then push coinciding with done at full
    push = 4'b0100;
    repeat (7) edge_();
    chk("ovf_pend7", 32'(pend_of(2)), 7);
    chk("ovf_none_yet", 32'(ovf), 0);
    edge_();
    push = 4'b0000;
    chk("ovf_pend_sat", 32'(pend_of(2)), 7);
    chk("ovf_pulse", 32'(ovf), 32'h4);
    edge_();
    chk("ovf_single", 32'(ovf), 0);
    gnt = 4'b0100;
    edge_();
    edge_();
    push = 4'b0100;
    #1;
    chk("ovf_done_full", 32'(done), 32'h4);
    edge_();
    push = 4'b0000;
    gnt  = 4'b0000;
    chk("ovf_pend_keep", 32'(pend_of(2)), 7);
    chk("ovf_no_pulse", 32'(ovf), 0);
    chk("ovf_rel_req", 32'(req & 4'b0100), 0);
    rst = 1'b1;
    edge_();
    rst = 1'b0;
    chk("midrst_pend", 32'(pend), 0);
    chk("midrst_req", 32'(req), 0);

    // Grant pause on channel 1
    push = 4'b0010;
    edge_();
    push = 4'b0000;
    edge_();
    chk("pz_req", 32'(req), 32'h2);
    gnt = 4'b0010;
    edge_();
    gnt = 4'b0000;
    edge_();
    #1;
    chk("pz_nominal_nodone", 32'(done), 0);
    edge_();
    gnt = 4'b0010;
    #1;
    chk("pz_req_held", 32'(req), 32'h2);
    chk("pz_done_early", 32'(done), 0);
    edge_();
    #1;
    chk("pz_done_late", 32'(done), 32'h2);
    edge_();
    gnt = 4'b0000;
    chk("pz_rel_req", 32'(req), 0);
    chk("pz_pend", 32'(pend_of(1)), 0);

    // Checker: two grants to requesting channels, then an unrequested grant
    push = 4'b0011;
    edge_();
    push = 4'b0000;
    edge_();
    chk("ck_req", 32'(req), 32'h3);
    gnt = 4'b0011;
    edge_();
    gnt = 4'b1000;
    chk("ck_multi", 32'(err_multi), 1);
    chk("ck_multi_unreq", 32'(err_unreq), 0);
    edge_();
    gnt = 4'b0000;
    chk("ck_unreq", 32'(err_unreq), 1);
    chk("ck_unreq_multi", 32'(err_multi), 0);
    chk("ck_req_kept", 32'(req), 32'h3);
    edge_();
    chk("ck_clear", 32'({err_multi, err_unreq}), 0);
    rst = 1'b1;
    edge_();
    rst = 1'b0;
    chk("ck_rst_pend", 32'(pend), 0);

`ifdef ARB_REQ_GRANT_TMO_EN
    // Grant-wait watchdog on channel 0, never granted
    push = 4'b0001;
    edge_();
    push = 4'b0000;
    edge_();
    chk("tmo_req_up", 32'(req), 32'h1);
    repeat (30) edge_();
    chk("tmo_not_yet", 32'(tmo), 0);
    chk("tmo_req_wait", 32'(req), 32'h1);
    edge_();
    chk("tmo_pulse", 32'(tmo), 32'h1);
    chk("tmo_rel_req", 32'(req), 0);
    chk("tmo_pend", 32'(pend_of(0)), 1);
    edge_();
    chk("tmo_single", 32'(tmo), 0);
    chk("tmo_retry", 32'(req), 32'h1);
    chk("tmo_pend_keep", 32'(pend_of(0)), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arbiter_requester.md
Name: arbiter_requester

Overview:
- Client-side counterpart of the 4-way round-robin arbiter: N independent channels queue transactions, raise `req`, consume `gnt`, hold ownership for a fixed burst, then release.
- Sits between local transaction sources and the arbiter's `req`/`gnt` interface.
- Includes a protocol checker that flags illegal grant patterns from the arbiter.

Parameters:
- N, 4, number of request channels (width of `req`/`gnt`)
- BURST_LEN, 3, granted cycles a channel owns the resource per transaction (≥1)
- PEND_MAX, 7, max queued transactions per channel; CNT_W = $clog2(PEND_MAX+1)
- TMO_CYC, 31, grant-wait watchdog limit (optional feature only)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- push  in  N  enqueue one transaction on channel i (pulse per transaction)
- gnt  in  N  grant vector from arbiter
- req  out  N  request vector to arbiter
- pend_cnt  out  N*CNT_W  queued-transaction count per channel (channel i at bits [i*CNT_W +: CNT_W])
- done  out  N  one-cycle pulse when channel i completes a burst
- ovf  out  N  one-cycle pulse: push to a full channel was dropped
- err_multi  out  1  one-cycle pulse: more than one `gnt` bit high
- err_unreq  out  1  one-cycle pulse: `gnt[i]` high while `req[i]` low

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: `req`, `pend_cnt`, `done`, `ovf`, `err_*` = 0. All channel FSMs go to IDLE. Reset mid-burst aborts immediately and drops queued work.
- Per-channel FSM:
  - IDLE: `req`=0. Go to REQ next cycle when `pend_cnt`>0 (including the cycle after the first push).
  - REQ: `req`=1. Go to OWN on the first cycle with `gnt[i]`=1; that cycle counts as granted cycle 1.
  - OWN: `req`=1. Burst counter increments on each cycle with `gnt[i]`=1. If `gnt[i]` drops mid-burst, the counter holds and the FSM stays in OWN (paused).
    - On granted cycle BURST_LEN: `done[i]` pulses that same cycle and `pend_cnt` decrements next edge. Go to RELEASE.
  - RELEASE: `req`=0 for exactly one cycle. Then go to REQ if `pend_cnt`>0, else IDLE.
  - With BURST_LEN=1, REQ→RELEASE directly on the grant cycle.
- `req` is a registered function of state; no combinational path `gnt`→`req`.
- Counter rules:
  - push only: +1.
  - done only: −1.
  - push and done in the same cycle: count unchanged, no `ovf`, even when at PEND_MAX.
  - push at PEND_MAX without done: dropped, `ovf[i]` pulses next cycle.
- Checker (registered, one-cycle latency):
  - `err_multi` when $countones(`gnt`)>1.
  - `err_unreq` when any `gnt[i]`&~`req[i]`.
  - Errors are reporting only; channel FSMs still act on `gnt`.
- Channels are fully independent; simultaneous events across channels are legal.

Optional Feature:
- Macro: ARB_REQ_GRANT_TMO_EN.
- When defined:
  - Adds output `tmo` (N bits) and a per-channel wait counter.
  - The counter runs in REQ and clears on leaving REQ.
  - When it reaches TMO_CYC, `tmo[i]` pulses one cycle and the channel goes to RELEASE, then retries. `pend_cnt` is not decremented.
- When undefined: no port, no counter; a channel waits in REQ indefinitely.

Decomposition:
- Package `arb_pkg`:
  - `req_state_t` enum {IDLE, REQ, OWN, RELEASE}.
  - Default N/BURST_LEN/PEND_MAX constants.
  - Function for CNT_W.
- Sub-module `arb_req_channel`: one channel's FSM, pending counter, burst counter and optional watchdog. Instantiated N times via generate.
- The top level holds the checker and the output packing.

Test Plan:
- Reset: assert `rst` for 2 cycles with `push`=4'b1111 → `req`=0, `pend_cnt`=0, no `done`; after release, `req` rises only on pushes issued after reset.
- Single channel: push ch0 once; arbiter model grants one cycle after `req[0]` and holds → `req[0]` high 1 cycle before plus BURST_LEN=3 granted cycles, `done[0]` on granted cycle 3, `req[0]` low 1 cycle, then IDLE with `pend_cnt[0]`=0.
- All four channels, 2 pushes each, round-robin arbiter model → 8 `done` pulses in order 0,1,2,3,0,1,2,3; every channel drops `req` one cycle between bursts; no `err_*`.
- Overflow: 8 pushes to ch2 with no grant → `pend_cnt[2]`=7 and one `ovf[2]` pulse. Then push coinciding with `done[2]` at count 7 → count stays 7, no `ovf`.
- Grant pause: `gnt[1]` low for 2 cycles mid-burst → burst resumes; `done[1]` 2 cycles later than nominal. Inject `gnt`=4'b0011 → `err_multi` next cycle. Inject `gnt[3]` with `req[3]`=0 → `err_unreq`.
- With ARB_REQ_GRANT_TMO_EN, TMO_CYC=31, push ch0, never grant → `tmo[0]` after 31 REQ cycles, `req[0]` low 1 cycle, retry, `pend_cnt[0]` still 1.
